instr_sequencer: RTL and testbench
==================================

# instr_sequencer

Instruction-issue stage directly upstream of the 8-bit common-bus CPU. It buffers 14-bit instructions arriving on a valid/ready interface in a small FIFO and presents each one on the CPU's `instruction` input for exactly the number of clocks the CPU needs to execute it: 7 clocks when opcode bits [3:0] equal the short opcode, 9 clocks otherwise. It also drives the CPU's `reg_val_or_pc` select, changing it only on instruction boundaries, and counts issued instructions.

## Interface
- `DEPTH`, 8: FIFO entries, power of two, at least 2.
- `SHORT_OPCODE`, 4'd1: value of instr[3:0] that selects the short execution length.
- `SHORT_CYCLES`, 7: clocks an instruction with the short opcode is held.
- `LONG_CYCLES`, 9: clocks any other instruction is held.

- `clock`  in  1  single clock; all state updates on rising edge.
- `reset_n`  in  1  asynchronous, active-low reset; clears all state immediately.
- `in_valid`  in  1  upstream offers `in_instr`.
- `in_ready`  out  1  FIFO can accept; equals (count != DEPTH).
- `in_instr`  in  14  instruction word offered upstream.
- `view_sel`  in  1  requested `reg_val_or_pc` value, sampled only at load edges.
- `instruction`  out  14  word presented to the CPU.
- `reg_val_or_pc`  out  1  CPU output select, registered.
- `instr_start`  out  1  high during the first held cycle of each instruction.
- `busy`  out  1  high while an instruction is being held (HOLD state).
- `fifo_count`  out  $clog2(DEPTH)+1  current FIFO occupancy.
- `issued_count`  out  8  instructions issued since reset, wraps 255->0.

## Operation
- Reset values: `instruction`=0, `reg_val_or_pc`=0, `instr_start`=0, `busy`=0, `fifo_count`=0, `issued_count`=0, `in_ready`=1, FSM=IDLE.
- FIFO: push on `in_valid && in_ready`. Pop only by the FSM load. Push and pop in the same cycle leave the count unchanged. There is no bypass: a word is always written before it can be loaded. When the FIFO is full, `in_ready`=0, so a push with a simultaneous pop at full is not possible.
- FSM states: IDLE, HOLD.
  - Load event: the FSM pops the head of the FIFO into `instruction`. It loads the hold counter with N-1, where N=SHORT_CYCLES if head[3:0]==SHORT_OPCODE, else LONG_CYCLES. It registers `view_sel` into `reg_val_or_pc`, sets `instr_start`=1 for the next cycle and increments `issued_count`.
  - IDLE: when the FIFO is non-empty, a load event occurs and the FSM goes to HOLD. Otherwise it stays in IDLE. `instruction` and `reg_val_or_pc` keep their last values.
  - HOLD: the counter decrements each clock. When the counter is 0, the FSM loads the next instruction if the FIFO is non-empty (back-to-back, no bubble, stays in HOLD). Otherwise it goes to IDLE.
- `busy` = (state==HOLD).
- `instr_start` is a single-cycle registered pulse and is 0 whenever no load occurred at the preceding edge.
- `view_sel` changes that occur mid-instruction have no effect until the next load edge.
- Counter width is sufficient for max(SHORT_CYCLES, LONG_CYCLES)-1.
- Reset asserted mid-hold aborts the instruction immediately, clears the FIFO (entries are discarded) and returns all outputs to their reset values.

## Timing
- Push accepted at edge t with the FIFO empty and FSM in IDLE: the load occurs at edge t+1, and the new `instruction` is visible from t+1.
- Each instruction is held for exactly N rising edges: it loads at edge L and is replaced or frozen at edge L+N.
- For back-to-back issue, consecutive `instr_start` pulses are exactly N cycles apart.
- `in_ready` is combinational from `fifo_count` only and does not depend on `in_valid`.
- `fifo_count` reflects a push or pop from the edge on which it occurs.

## Test plan
- Reset: hold `reset_n`=0 for 3 clocks, then release -> all outputs are at their reset values, `in_ready`=1, and `busy` stays 0 with no input.
- Single short instruction: push 14'b00000000010001 -> `instruction` loads one edge later, `instr_start` pulses once, `busy` is high for 7 cycles then 0, and `issued_count`=1.
- Back-to-back mix: push 14'h0011, 14'h0022, 14'h0031 in consecutive cycles -> the instructions are held for 7, 9 and 7 cycles with no bubbles, `instr_start` pulses are 7 and 9 cycles apart, and the final `issued_count`=3.
- Full FIFO: push 8 words while one 9-cycle instruction is held -> `in_ready`=0 when `fifo_count`=8, a further `in_valid` is not accepted, and `in_ready` returns to 1 on the next load edge.
- Select gating: set `view_sel`=1 mid-hold of instruction A -> `reg_val_or_pc` stays 0 until B loads, then becomes 1 on the same edge as B.
- Reset mid-operation: assert `reset_n` during cycle 4 of a 9-cycle hold with 3 words queued -> `instruction`=0 and `fifo_count`=0 immediately, and there is no issue after release until a new push.

Source files
------------

// File: rtl/instr_sequencer.sv
// Instruction-issue stage: FIFO-buffers 14-bit instructions and holds each on
// the CPU instruction bus for its opcode-dependent execution length.
module instr_sequencer #(
  parameter int          DEPTH        = 8,
  parameter logic [3:0]  SHORT_OPCODE = 4'd1,
  parameter int          SHORT_CYCLES = 7,
  parameter int          LONG_CYCLES  = 9
) (
  input  logic                       clock,
  input  logic                       reset_n,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [13:0]                in_instr,
  input  logic                       view_sel,
  output logic [13:0]                instruction,
  output logic                       reg_val_or_pc,
  output logic                       instr_start,
  output logic                       busy,
  output logic [$clog2(DEPTH):0]     fifo_count,
  output logic [7:0]                 issued_count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int MAXC  = (SHORT_CYCLES > LONG_CYCLES) ? SHORT_CYCLES : LONG_CYCLES;
  localparam int HC_W  = (MAXC > 2) ? $clog2(MAXC) : 1;

  typedef enum logic {IDLE, HOLD} state_t;

  state_t            state_q, state_d;
  logic [13:0]       mem_q [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [HC_W-1:0]   hold_cnt_q, hold_cnt_d;
  logic [13:0]       instr_q, instr_d;
  logic              rvp_q, rvp_d;
  logic              start_q, start_d;
  logic [7:0]        issued_q, issued_d;

  logic              push;
  logic              load;
  logic              hold_done;
  logic [13:0]       head;

  assign in_ready      = (count_q != CNT_W'(DEPTH));
  assign instruction   = instr_q;
  assign reg_val_or_pc = rvp_q;
  assign instr_start   = start_q;
  assign busy          = (state_q == HOLD);
  assign fifo_count    = count_q;
  assign issued_count  = issued_q;

  always_comb begin
    push       = in_valid && in_ready;
    head       = mem_q[rd_ptr_q];
    hold_done  = (hold_cnt_q == '0);
    // A load happens from IDLE or on the last held cycle, whenever data waits.
    load       = (count_q != '0) && ((state_q == IDLE) || hold_done);

    state_d    = state_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    hold_cnt_d = hold_cnt_q;
    instr_d    = instr_q;
    rvp_d      = rvp_q;
    start_d    = load;
    issued_d   = issued_q;

    if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (load) rd_ptr_d = rd_ptr_q + PTR_W'(1);

    if (push && !load)      count_d = count_q + CNT_W'(1);
    else if (!push && load) count_d = count_q - CNT_W'(1);

    if (load) begin
      state_d    = HOLD;
      instr_d    = head;
      rvp_d      = view_sel;
      issued_d   = issued_q + 8'd1;
      hold_cnt_d = (head[3:0] == SHORT_OPCODE) ? HC_W'(SHORT_CYCLES - 1)
                                               : HC_W'(LONG_CYCLES - 1);
    end else if (state_q == HOLD) begin
      if (hold_done) state_d = IDLE;
      else           hold_cnt_d = hold_cnt_q - HC_W'(1);
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      hold_cnt_q <= '0;
      instr_q    <= '0;
      rvp_q      <= 1'b0;
      start_q    <= 1'b0;
      issued_q   <= '0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      hold_cnt_q <= hold_cnt_d;
      instr_q    <= instr_d;
      rvp_q      <= rvp_d;
      start_q    <= start_d;
      issued_q   <= issued_d;
    end
  end

  // Storage needs no reset: entries are only visible through the pointers.
  always_ff @(posedge clock) begin
    if (push) mem_q[wr_ptr_q] <= in_instr;
  end

endmodule

// File: tb/tb_instr_sequencer.sv
// Directed bench for instr_sequencer: reset, short/long hold lengths,
// back-to-back issue, full FIFO, select gating and mid-hold reset.
module tb_instr_sequencer;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        in_valid;
  logic        in_ready;
  logic [13:0] in_instr;
  logic        view_sel;
  logic [13:0] instruction;
  logic        reg_val_or_pc;
  logic        instr_start;
  logic        busy;
  logic [3:0]  fifo_count;
  logic [7:0]  issued_count;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int nst = 0;
  int starts [16];
  logic [13:0] sinstr [16];

  instr_sequencer dut (
    .clock(clock), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_instr(in_instr), .view_sel(view_sel), .instruction(instruction),
    .reg_val_or_pc(reg_val_or_pc), .instr_start(instr_start), .busy(busy),
    .fifo_count(fifo_count), .issued_count(issued_count)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock, settle 1ns past the edge and log instr_start pulses.
  task automatic step();
    @(posedge clock);
    #1;
    cyc++;
    if (instr_start === 1'b1 && nst < 16) begin
      starts[nst] = cyc;
      sinstr[nst] = instruction;
      nst++;
    end
  endtask

  task automatic do_reset();
    reset_n  = 1'b0;
    in_valid = 1'b0;
    in_instr = '0;
    view_sel = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    reset_n = 1'b1;
    nst = 0;
  endtask

  initial begin
    int n;
    // ---------------- reset ----------------
    reset_n = 1'b1; in_valid = 1'b0; in_instr = '0; view_sel = 1'b0;
    #2;
    do_reset();
    chk("rst_instruction", 32'(instruction), 32'h0);
    chk("rst_rvp", 32'(reg_val_or_pc), 32'h0);
    chk("rst_start", 32'(instr_start), 32'h0);
    chk("rst_fifo_count", 32'(fifo_count), 32'h0);
    chk("rst_issued", 32'(issued_count), 32'h0);
    chk("rst_in_ready", 32'(in_ready), 32'h1);
    repeat (4) step();
    chk("idle_busy", 32'(busy), 32'h0);
    chk("idle_issued", 32'(issued_count), 32'h0);

    // ---------------- single short instruction ----------------
    in_valid = 1'b1; in_instr = 14'b00000000010001;
    step();
    in_valid = 1'b0;
    chk("single_count_after_push", 32'(fifo_count), 32'h1);
    chk("single_busy_before_load", 32'(busy), 32'h0);
    step();
    chk("single_instruction", 32'(instruction), 32'h0011);
    chk("single_start", 32'(instr_start), 32'h1);
    chk("single_fifo_empty", 32'(fifo_count), 32'h0);
    n = 0;
    while (busy === 1'b1 && n < 30) begin n++; step(); end
    chk("single_busy_cycles", 32'(n), 32'd7);
    chk("single_start_pulses", 32'(nst), 32'd1);
    chk("single_issued", 32'(issued_count), 32'd1);
    chk("single_instr_frozen", 32'(instruction), 32'h0011);

    // ---------------- back-to-back mix ----------------
    do_reset();
    in_valid = 1'b1; in_instr = 14'h0011; step();
    in_instr = 14'h0022; step();
    in_instr = 14'h0031; step();
    in_valid = 1'b0;
    n = 0;
    while (busy === 1'b1 && n < 60) begin n++; step(); end
    chk("b2b_pulses", 32'(nst), 32'd3);
    chk("b2b_first", 32'(sinstr[0]), 32'h0011);
    chk("b2b_second", 32'(sinstr[1]), 32'h0022);
    chk("b2b_third", 32'(sinstr[2]), 32'h0031);
    chk("b2b_gap_short", 32'(starts[1] - starts[0]), 32'd7);
    chk("b2b_gap_long", 32'(starts[2] - starts[1]), 32'd9);
    chk("b2b_last_hold", 32'(cyc - starts[2]), 32'd7);
    chk("b2b_issued", 32'(issued_count), 32'd3);

    // ---------------- full FIFO ----------------
    do_reset();
    in_valid = 1'b1; in_instr = 14'h0002; step();
    in_valid = 1'b0; step();
    chk("full_first_load", 32'(instruction), 32'h0002);
    in_valid = 1'b1;
    for (int k = 0; k < 8; k++) begin
      in_instr = 14'h0100 + 14'(k);
      step();
    end
    chk("full_count", 32'(fifo_count), 32'd8);
    chk("full_not_ready", 32'(in_ready), 32'h0);
    in_valid = 1'b0;
    #1;
    chk("full_ready_no_valid", 32'(in_ready), 32'h0);
    in_valid = 1'b1; in_instr = 14'h3FF0;
    step();
    in_valid = 1'b0;
    chk("full_ready_after_load", 32'(in_ready), 32'h1);
    chk("full_count_after_load", 32'(fifo_count), 32'd7);
    chk("full_next_instr", 32'(instruction), 32'h0100);
    chk("full_next_start", 32'(instr_start), 32'h1);

    // ---------------- select gating ----------------
    do_reset();
    in_valid = 1'b1; in_instr = 14'h0011; step();
    in_instr = 14'h0022; step();
    in_valid = 1'b0;
    chk("sel_a_rvp", 32'(reg_val_or_pc), 32'h0);
    step(); step();
    view_sel = 1'b1;
    for (int k = 0; k < 4; k++) step();
    chk("sel_mid_hold_rvp", 32'(reg_val_or_pc), 32'h0);
    chk("sel_still_a", 32'(instruction), 32'h0011);
    step();
    chk("sel_b_loaded", 32'(instruction), 32'h0022);
    chk("sel_b_rvp", 32'(reg_val_or_pc), 32'h1);

    // ---------------- reset mid-operation ----------------
    do_reset();
    in_valid = 1'b1; in_instr = 14'h0002; step();
    in_instr = 14'h0103; step();
    in_instr = 14'h0104; step();
    in_instr = 14'h0105; step();
    in_valid = 1'b0;
    chk("mid_queued", 32'(fifo_count), 32'd3);
    step();
    #2;
    reset_n = 1'b0;
    #1;
    chk("mid_instruction", 32'(instruction), 32'h0);
    chk("mid_fifo_count", 32'(fifo_count), 32'h0);
    chk("mid_busy", 32'(busy), 32'h0);
    chk("mid_issued", 32'(issued_count), 32'h0);
    repeat (2) @(posedge clock);
    #1;
    reset_n = 1'b1;
    nst = 0;
    for (int k = 0; k < 12; k++) step();
    chk("mid_no_issue", 32'(nst), 32'd0);
    chk("mid_idle_busy", 32'(busy), 32'h0);
    in_valid = 1'b1; in_instr = 14'h0007; step();
    in_valid = 1'b0; step();
    chk("mid_new_load", 32'(instruction), 32'h0007);
    chk("mid_new_issued", 32'(issued_count), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
